uart_rx_irq: RTL and testbench

- UART receive peripheral that drives the core's top-level INTERRUPT input. This block is the device end of the interrupt line the core's writeback stage samples.
- It deserialises 8N1 frames from a serial line into a small FIFO and raises a level interrupt while data is pending and interrupts are enabled.
- The core's trap handler drains the FIFO through a simple read-strobe interface.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_irq_sync_fifo.sv | 58 +++++
 rtl/uart_rx_irq.sv | 147 ++++++++++++++
 tb/tb_uart_rx_irq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-interrupt block.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_irq_sync_fifo.sv
// Single-clock FIFO. A push and a pop in the same cycle are both honoured,
// including when full: the slot being vacated by the pop receives the new word.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  // Occupancy after this edge, also used by the owner to register its interrupt.
  always_comb begin
    count_next = count;
    count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

endmodule

// File: rtl/uart_rx_irq.sv
// 8N1 UART receiver feeding a small FIFO, with a level interrupt to the core
// while bytes are pending and sticky framing/overrun error flags.
module uart_rx_irq
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          RXD,
  input  logic                          IRQ_EN,
  input  logic                          RD_EN,
  output logic [UART_DATA_W-1:0]        RD_DATA,
  output logic                          RD_VALID,
  output logic                          INTERRUPT,
  output logic [$clog2(FIFO_DEPTH):0]   RX_COUNT,
  output logic                          FRAME_ERR,
  output logic                          OVERRUN,
  input  logic                          ERR_CLR
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_BIT = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_BIT = BAUD_W'(CLKS_PER_BIT - 1);

  rx_state_t                  state;
  logic                       rx_meta;
  logic                       rxs;
  logic [BAUD_W-1:0]          baud_cnt;
  logic [2:0]                 bit_cnt;
  logic [UART_DATA_W-1:0]     shift;
  logic                       push_req;
  logic                       stop_sample;
  logic [UART_DATA_W-1:0]     fifo_dout;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] count_next;

  assign stop_sample = (state == STOP) && (baud_cnt == FULL_BIT);

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rxs     <= rx_meta;
    end
  end

  // Receive FSM: start-bit qualification, LSB-first data sampling, stop check.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      push_req <= 1'b0;
    end else begin
      push_req <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (baud_cnt == HALF_BIT) begin
            baud_cnt <= '0;
            state    <= rxs ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_cnt == FULL_BIT) begin
            baud_cnt <= '0;
            shift    <= {rxs, shift[UART_DATA_W-1:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_cnt == FULL_BIT) begin
            baud_cnt <= '0;
            push_req <= rxs;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst        (RESET),
    .push       (push_req),
    .pop        (RD_EN),
    .din        (shift),
    .dout       (fifo_dout),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (RX_COUNT),
    .count_next (count_next)
  );

  // Read port: register the head byte and a one-cycle qualifier on each pop.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= RD_EN && !fifo_empty;
      if (RD_EN && !fifo_empty) RD_DATA <= fifo_dout;
    end
  end

  // Level interrupt tracks the occupancy this edge produces.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) INTERRUPT <= 1'b0;
    else       INTERRUPT <= IRQ_EN && (count_next != '0);
  end

  // Sticky error flags; a set in the same cycle wins over ERR_CLR.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (stop_sample && !rxs)                 FRAME_ERR <= 1'b1;
      else if (ERR_CLR)                        FRAME_ERR <= 1'b0;
      if (push_req && fifo_full && !RD_EN)     OVERRUN   <= 1'b1;
      else if (ERR_CLR)                        OVERRUN   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_irq.sv
// Directed plus randomised bench for uart_rx_irq with CLKS_PER_BIT=16, FIFO_DEPTH=4.
module tb_uart_rx_irq;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       RXD = 1'b1;
  logic       IRQ_EN = 1'b0;
  logic       RD_EN = 1'b0;
  logic [7:0] RD_DATA;
  logic       RD_VALID;
  logic       INTERRUPT;
  logic [2:0] RX_COUNT;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       ERR_CLR = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_irq #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .RXD       (RXD),
    .IRQ_EN    (IRQ_EN),
    .RD_EN     (RD_EN),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .INTERRUPT (INTERRUPT),
    .RX_COUNT  (RX_COUNT),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
    .ERR_CLR   (ERR_CLR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One 8N1 frame, each bit held for CPB cycles; stop_ok=0 sends a low stop bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    @(negedge CLK) RXD = 1'b0;
    repeat (CPB - 1) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK) RXD = b[i];
      repeat (CPB - 1) @(negedge CLK);
    end
    @(negedge CLK) RXD = stop_ok;
    repeat (CPB - 1) @(negedge CLK);
    if (!stop_ok) begin
      @(negedge CLK) RXD = 1'b1;
      repeat (3 * CPB) @(negedge CLK);
    end
  endtask

  // One-cycle read strobe, then check the registered result.
  task automatic do_read(input string tag, input bit exp_valid, input logic [7:0] exp_data);
    @(negedge CLK) RD_EN = 1'b1;
    @(negedge CLK) RD_EN = 1'b0;
    check({tag, "_valid"}, RD_VALID, exp_valid);
    check({tag, "_data"}, RD_DATA, exp_data);
  endtask

  task automatic pulse_clr();
    @(negedge CLK) ERR_CLR = 1'b1;
    @(negedge CLK) ERR_CLR = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] last_data;
  logic [7:0] b;
  bit         ok;
  bit         m_ferr;
  bit         m_ovr;
  int         nr;
  int         t;

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_count", RX_COUNT, 0);
    check("rst_irq", INTERRUPT, 0);
    check("rst_valid", RD_VALID, 0);
    check("rst_data", RD_DATA, 0);
    check("rst_ferr", FRAME_ERR, 0);
    check("rst_ovr", OVERRUN, 0);
    RESET = 1'b0;
    IRQ_EN = 1'b1;
    repeat (4) @(negedge CLK);

    // Single frame
    send_frame(8'hA5, 1'b1);
    check("single_count", RX_COUNT, 1);
    check("single_irq", INTERRUPT, 1);
    do_read("single_rd", 1'b1, 8'hA5);
    check("single_irq_off", INTERRUPT, 0);
    check("single_count0", RX_COUNT, 0);
    last_data = 8'hA5;

    // Glitch rejection
    @(negedge CLK) RXD = 1'b0;
    repeat (4) @(negedge CLK);
    RXD = 1'b1;
    repeat (3 * CPB) @(negedge CLK);
    check("glitch_count", RX_COUNT, 0);
    check("glitch_ferr", FRAME_ERR, 0);

    // Frame error, then clear
    send_frame(8'h3C, 1'b0);
    check("ferr_set", FRAME_ERR, 1);
    check("ferr_count", RX_COUNT, 0);
    pulse_clr();
    check("ferr_clr", FRAME_ERR, 0);

    // Overrun: five back-to-back frames with no reads
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    check("ovr_count", RX_COUNT, 4);
    check("ovr_flag", OVERRUN, 1);
    for (int i = 1; i <= 4; i++) do_read("ovr_rd", 1'b1, 8'(i));
    do_read("ovr_empty_rd", 1'b0, 8'h04);
    pulse_clr();
    check("ovr_clr", OVERRUN, 0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    check("full_count", RX_COUNT, 4);
    fork
      send_frame(8'h77, 1'b1);
      begin
        t = 0;
        while (dut.push_req !== 1'b1 && t < 400) begin
          @(negedge CLK);
          t++;
        end
        check("pp_push_seen", t < 400, 1);
        RD_EN = 1'b1;
        @(negedge CLK) RD_EN = 1'b0;
        check("pp_valid", RD_VALID, 1);
        check("pp_data", RD_DATA, 8'h10);
      end
    join
    check("pp_ovr", OVERRUN, 0);
    check("pp_count", RX_COUNT, 4);
    do_read("pp_rd1", 1'b1, 8'h11);
    do_read("pp_rd2", 1'b1, 8'h12);
    do_read("pp_rd3", 1'b1, 8'h13);
    do_read("pp_rd4", 1'b1, 8'h77);

    // Interrupt gating
    IRQ_EN = 1'b0;
    send_frame(8'h42, 1'b1);
    check("gate_count", RX_COUNT, 1);
    check("gate_irq_off", INTERRUPT, 0);
    @(negedge CLK) IRQ_EN = 1'b1;
    @(negedge CLK);
    check("gate_irq_on", INTERRUPT, 1);

    // Reset in the middle of data bit 3
    @(negedge CLK) RXD = 1'b0;
    repeat (CPB - 1) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK) RXD = i[0];
      repeat (CPB - 1) @(negedge CLK);
    end
    @(negedge CLK) RXD = 1'b1;
    repeat (CPB / 2) @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("mid_rst_count", RX_COUNT, 0);
    check("mid_rst_irq", INTERRUPT, 0);
    check("mid_rst_data", RD_DATA, 0);
    check("mid_rst_valid", RD_VALID, 0);
    check("mid_rst_ferr", FRAME_ERR, 0);
    check("mid_rst_ovr", OVERRUN, 0);
    RXD = 1'b1;
    @(negedge CLK) RESET = 1'b0;
    repeat (4) @(negedge CLK);
    send_frame(8'h5A, 1'b1);
    check("post_rst_count", RX_COUNT, 1);
    do_read("post_rst_rd", 1'b1, 8'h5A);

    // Randomised frames and reads against a queue model
    q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    last_data = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok);
      if (!ok)                 m_ferr = 1'b1;
      else if (q.size() < DEPTH) q.push_back(b);
      else                     m_ovr = 1'b1;
      check("rnd_count", RX_COUNT, q.size());
      check("rnd_ferr", FRAME_ERR, m_ferr);
      check("rnd_ovr", OVERRUN, m_ovr);
      check("rnd_irq", INTERRUPT, q.size() != 0);
      nr = $urandom_range(0, 2);
      for (int k = 0; k < nr; k++) begin
        if (q.size() != 0) begin
          last_data = q.pop_front();
          do_read("rnd_rd", 1'b1, last_data);
        end else begin
          do_read("rnd_rd_empty", 1'b0, last_data);
        end
      end
    end
    while (q.size() != 0) begin
      last_data = q.pop_front();
      do_read("rnd_drain", 1'b1, last_data);
    end
    check("rnd_final_count", RX_COUNT, 0);
    check("rnd_final_irq", INTERRUPT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
